// File: rtl/pipeline_pkg.sv
// Shared types, constants and helpers for the elastic inter-stage registers.
package pipeline_pkg;

   // Widest payload any stage may carry; apply_safe works at this width.
   localparam int unsigned MaxPayloadW = 1024;

   typedef logic [MaxPayloadW-1:0] payload_t;

   // One storage entry as seen by the pipeline.
   typedef struct packed {
      logic     valid;
      logic     invalid;
      payload_t payload;
   } slot_t;

   // Same encoding as BRANCH_FORCE_FALSE in the core's defines.vh.
   localparam logic [1:0] BRANCH_FORCE_FALSE = 2'b00;

   // Safe values for control fields commonly placed under SAFE_MASK.
   localparam logic [1:0] SafeBranch    = BRANCH_FORCE_FALSE;
   localparam logic       SafeRegfileWe = 1'b0;
   localparam logic       SafeLsuWe     = 1'b0;

   // Replace masked bits of a payload with their safe value.
   function automatic payload_t apply_safe(payload_t payload, payload_t mask, payload_t value);
      return (payload & ~mask) | (value & mask);
   endfunction

endpackage

// File: rtl/pipeline_slot.sv
// Single storage entry (valid, invalid tag, payload) with load/clear/hold controls.
module pipeline_slot #(
   parameter int unsigned PAYLOAD_W = 128
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 clear_i,
   input  logic                 invalid_i,
   input  logic [PAYLOAD_W-1:0] payload_i,
   output logic                 valid_o,
   output logic                 invalid_o,
   output logic [PAYLOAD_W-1:0] payload_o
);

   logic                 valid_q, valid_d;
   logic                 invalid_q, invalid_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;

   // Next state: clear beats load, otherwise hold. Payload is kept on clear.
   always_comb begin
      valid_d   = valid_q;
      invalid_d = invalid_q;
      payload_d = payload_q;
      if (clear_i) begin
         valid_d   = 1'b0;
         invalid_d = 1'b0;
      end else if (load_i) begin
         valid_d   = 1'b1;
         invalid_d = invalid_i;
         payload_d = payload_i;
      end
   end

   // Slot registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q   <= 1'b0;
         invalid_q <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         invalid_q <= invalid_d;
         payload_q <= payload_d;
      end
   end

   assign valid_o   = valid_q;
   assign invalid_o = invalid_q;
   assign payload_o = payload_q;

endmodule

// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake, optional skid slot, flush,
// invalid tag with safe-masking of control fields, and a saturating bubble counter.
module pipeline_stage_elastic
   import pipeline_pkg::*;
#(
   parameter int unsigned          PAYLOAD_W  = 128,
   parameter logic [PAYLOAD_W-1:0] SAFE_MASK  = '0,
   parameter logic [PAYLOAD_W-1:0] SAFE_VALUE = '0,
   parameter int unsigned          SKID       = 1,
   parameter int unsigned          CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic                 up_invalid,
   input  logic [PAYLOAD_W-1:0] up_payload,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic                 dn_invalid,
   output logic [PAYLOAD_W-1:0] dn_payload,
   output logic [CNT_W-1:0]     bubble_count
);

   logic                 main_valid, main_invalid;
   logic [PAYLOAD_W-1:0] main_payload;
   logic                 skid_valid, skid_invalid;
   logic [PAYLOAD_W-1:0] skid_payload;

   logic                 up_fire, dn_fire;
   logic                 main_load, main_from_skid, main_clear;
   logic                 skid_load, skid_clear, skid_valid_next;
   logic                 main_load_invalid;
   logic [PAYLOAD_W-1:0] main_load_payload;

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   payload_t             masked_wide;

   assign up_fire = up_valid & up_ready;
   assign dn_fire = main_valid & dn_ready;

   // Slot steering: skid refills main first, so order is preserved and skid
   // only fills while main stays occupied.
   always_comb begin
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_clear     = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (dn_fire && skid_valid) begin
         main_load      = 1'b1;
         main_from_skid = 1'b1;
         skid_clear     = 1'b1;
      end else if (up_fire && (!main_valid || dn_fire)) begin
         main_load = 1'b1;
      end else if (up_fire) begin
         skid_load = 1'b1;
      end else if (dn_fire) begin
         main_clear = 1'b1;
      end
      main_load_invalid = main_from_skid ? skid_invalid : up_invalid;
      main_load_payload = main_from_skid ? skid_payload : up_payload;
      skid_valid_next   = skid_load | (skid_valid & ~skid_clear);
   end

   pipeline_slot #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_main (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (main_load),
      .clear_i   (main_clear),
      .invalid_i (main_load_invalid),
      .payload_i (main_load_payload),
      .valid_o   (main_valid),
      .invalid_o (main_invalid),
      .payload_o (main_payload)
   );

   if (SKID != 0) begin : g_skid
      logic up_ready_q, up_ready_d;

      pipeline_slot #(
         .PAYLOAD_W (PAYLOAD_W)
      ) u_skid (
         .clk_i     (clk),
         .rst_i     (rst),
         .load_i    (skid_load),
         .clear_i   (skid_clear),
         .invalid_i (up_invalid),
         .payload_i (up_payload),
         .valid_o   (skid_valid),
         .invalid_o (skid_invalid),
         .payload_o (skid_payload)
      );

      assign up_ready_d = ~skid_valid_next;

      // Registered up_ready: ready exactly when the skid slot will be empty.
      always_ff @(posedge clk) begin
         if (rst) begin
            up_ready_q <= 1'b1;
         end else begin
            up_ready_q <= up_ready_d;
         end
      end

      assign up_ready = up_ready_q;
   end else begin : g_no_skid
      logic unused_skid_ctrl;

      assign skid_valid       = 1'b0;
      assign skid_invalid     = 1'b0;
      assign skid_payload     = '0;
      assign up_ready         = ~main_valid | dn_ready;
      assign unused_skid_ctrl = skid_load ^ skid_clear ^ skid_valid_next;
   end

   assign masked_wide = apply_safe(payload_t'(main_payload), payload_t'(SAFE_MASK),
                                   payload_t'(SAFE_VALUE));

   if (PAYLOAD_W < MaxPayloadW) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^masked_wide[MaxPayloadW-1:PAYLOAD_W];
   end

   // Output view: bubbles and invalid entries expose safe control fields.
   always_comb begin
      dn_payload = main_payload;
      if (!main_valid || main_invalid) begin
         dn_payload = masked_wide[PAYLOAD_W-1:0];
      end
   end

   assign dn_valid   = main_valid;
   assign dn_invalid = main_valid & main_invalid;

   // Bubble counter next state: count empty cycles the consumer could have used.
   always_comb begin
      cnt_d = cnt_q;
      if (dn_ready && !main_valid && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bubble_count = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: a SKID=1 (CNT_W=2) and a SKID=0 (CNT_W=4)
// instance share stimulus; each is compared against a queue model every cycle.
module tb_pipeline_stage_elastic;

   localparam logic [7:0] Mask  = 8'h0F;
   localparam logic [7:0] Value = 8'h05;

   logic       clk = 1'b0;
   logic       rst, flush, up_valid, up_invalid, dn_ready;
   logic [7:0] up_payload;

   logic       up_ready1, dn_valid1, dn_invalid1;
   logic [7:0] dn_payload1;
   logic [1:0] cnt1;
   logic       up_ready0, dn_valid0, dn_invalid0;
   logic [7:0] dn_payload0;
   logic [3:0] cnt0;

   int checks = 0;
   int passed = 0;

   logic [8:0] m1[$];
   logic [8:0] m0[$];
   int         c1m = 0;
   int         c0m = 0;
   logic [7:0] got[$];

   always #5 clk = ~clk;

   pipeline_stage_elastic #(
      .PAYLOAD_W  (8),
      .SAFE_MASK  (8'h0F),
      .SAFE_VALUE (8'h05),
      .SKID       (1),
      .CNT_W      (2)
   ) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .up_valid     (up_valid),
      .up_ready     (up_ready1),
      .up_invalid   (up_invalid),
      .up_payload   (up_payload),
      .dn_valid     (dn_valid1),
      .dn_ready     (dn_ready),
      .dn_invalid   (dn_invalid1),
      .dn_payload   (dn_payload1),
      .bubble_count (cnt1)
   );

   pipeline_stage_elastic #(
      .PAYLOAD_W  (8),
      .SAFE_MASK  (8'h0F),
      .SAFE_VALUE (8'h05),
      .SKID       (0),
      .CNT_W      (4)
   ) u_dut0 (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .up_valid     (up_valid),
      .up_ready     (up_ready0),
      .up_invalid   (up_invalid),
      .up_payload   (up_payload),
      .dn_valid     (dn_valid0),
      .dn_ready     (dn_ready),
      .dn_invalid   (dn_invalid0),
      .dn_payload   (dn_payload0),
      .bubble_count (cnt0)
   );

   function automatic logic [7:0] safe(input logic [7:0] p);
      return (p & ~Mask) | (Value & Mask);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic check_dut(input string n, input int cap, input int sz, input logic [8:0] front,
                            input int cexp, input logic ur, input logic v, input logic inv,
                            input logic [7:0] pl, input logic [15:0] cnt);
      logic exp_ur;
      exp_ur = (cap == 2) ? (sz < 2) : ((sz == 0) || dn_ready);
      check({n, "_up_ready"}, 16'(ur), 16'(exp_ur));
      check({n, "_dn_valid"}, 16'(v), 16'(sz > 0));
      check({n, "_bubble_count"}, cnt, 16'(cexp));
      if (sz > 0) begin
         check({n, "_dn_invalid"}, 16'(inv), 16'(front[8]));
         check({n, "_dn_payload"}, 16'(pl), 16'(front[8] ? safe(front[7:0]) : front[7:0]));
      end else begin
         check({n, "_idle_invalid"}, 16'(inv), 16'h0);
         check({n, "_idle_masked"}, 16'(pl & Mask), 16'(Value & Mask));
      end
   endtask

   task automatic compare_all();
      check_dut("skid1", 2, m1.size(), (m1.size() > 0) ? m1[0] : 9'h0, c1m, up_ready1,
                dn_valid1, dn_invalid1, dn_payload1, 16'(cnt1));
      check_dut("skid0", 1, m0.size(), (m0.size() > 0) ? m0[0] : 9'h0, c0m, up_ready0,
                dn_valid0, dn_invalid0, dn_payload0, 16'(cnt0));
   endtask

   // Advance the models by one clock from the current inputs, clock the DUTs,
   // then compare at the following falling edge.
   task automatic cycle();
      logic ur1, ur0;
      #1;
      if (!rst && dn_valid1 && dn_ready) got.push_back(dn_payload1);
      ur1 = (m1.size() < 2);
      ur0 = (m0.size() == 0) || dn_ready;
      if (rst) begin
         m1.delete();
         c1m = 0;
      end else begin
         if (dn_ready && m1.size() == 0 && c1m < 3) c1m++;
         if (flush) m1.delete();
         else begin
            if (dn_ready && m1.size() > 0) void'(m1.pop_front());
            if (up_valid && ur1) m1.push_back({up_invalid, up_payload});
         end
      end
      if (rst) begin
         m0.delete();
         c0m = 0;
      end else begin
         if (dn_ready && m0.size() == 0 && c0m < 15) c0m++;
         if (flush) m0.delete();
         else begin
            if (dn_ready && m0.size() > 0) void'(m0.pop_front());
            if (up_valid && ur0) m0.push_back({up_invalid, up_payload});
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      logic [7:0] seq[4];
      int         exp_cnt[5];
      int         idx;
      int         cyc;
      logic       take;

      seq     = '{8'h01, 8'h02, 8'h03, 8'h04};
      exp_cnt = '{0, 1, 2, 3, 3};

      rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_invalid = 1'b0;
      up_payload = 8'h00; dn_ready = 1'b0;
      cycle();
      cycle();

      // Reset values
      check("rst_payload1", 16'(dn_payload1), 16'h05);
      check("rst_payload0", 16'(dn_payload0), 16'h05);
      check("rst_up_ready1", 16'(up_ready1), 16'h1);

      // Bubble counter saturation with CNT_W=2
      rst = 1'b0; dn_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bubble_seq", 16'(cnt1), 16'(exp_cnt[i]));
         cycle();
      end

      // Valid push: one cycle latency, payload unmodified
      dn_ready = 1'b0; up_valid = 1'b1; up_payload = 8'hAB;
      cycle();
      check("push_valid", 16'(dn_valid1), 16'h1);
      check("push_payload", 16'(dn_payload1), 16'hAB);
      up_valid = 1'b0; dn_ready = 1'b1;
      cycle();

      // Invalid push: control nibble forced
      dn_ready = 1'b0; up_valid = 1'b1; up_invalid = 1'b1; up_payload = 8'hFF;
      cycle();
      check("inv_valid", 16'(dn_valid1), 16'h1);
      check("inv_tag", 16'(dn_invalid1), 16'h1);
      check("inv_payload", 16'(dn_payload1), 16'hF5);
      up_valid = 1'b0; up_invalid = 1'b0; dn_ready = 1'b1;
      cycle();

      // Stream 1..4 through a dn_ready stall
      got.delete();
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 40) begin
         up_valid   = 1'b1;
         up_payload = seq[idx];
         dn_ready   = !(cyc >= 1 && cyc < 5);
         take       = up_ready1;
         cycle();
         if (take) idx++;
         if (cyc == 1) check("stall_up_ready_low", 16'(up_ready1), 16'h0);
         if (cyc == 5) check("release_up_ready_back", 16'(up_ready1), 16'h1);
         cyc++;
      end
      check("stream_all_taken", 16'(idx), 16'd4);
      up_valid = 1'b0; dn_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      check("stream_count", 16'(got.size()), 16'd4);
      for (int i = 0; i < 4; i++) begin
         check("stream_order", 16'((i < got.size()) ? got[i] : 8'hXX), 16'(seq[i]));
      end

      // Full stage, then flush with a beat on the input
      dn_ready = 1'b0; up_valid = 1'b1; up_payload = 8'h11;
      cycle();
      up_payload = 8'h22;
      cycle();
      up_valid = 1'b0;
      cycle();
      check("full_up_ready", 16'(up_ready1), 16'h0);
      check("full_hold_payload", 16'(dn_payload1), 16'h11);
      flush = 1'b1; up_valid = 1'b1; up_payload = 8'h33;
      cycle();
      check("flush_dn_valid", 16'(dn_valid1), 16'h0);
      flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 3; i++) cycle();
      check("flush_nothing_out", 16'(got.size()), 16'd0);

      // Flush while ready: accepted beat is discarded, draining beat is consumed
      dn_ready = 1'b0; up_valid = 1'b1; up_payload = 8'h44;
      cycle();
      flush = 1'b1; up_payload = 8'h55; dn_ready = 1'b1;
      cycle();
      check("flush_accept_discard", 16'(dn_valid1), 16'h0);
      flush = 1'b0; up_valid = 1'b0;
      cycle();

      // Reset while full with SKID=0
      dn_ready = 1'b0; up_valid = 1'b1; up_invalid = 1'b1; up_payload = 8'h66;
      cycle();
      up_invalid = 1'b0; up_payload = 8'h77;
      cycle();
      check("pre_rst_full0", 16'(dn_valid0), 16'h1);
      up_valid = 1'b0; rst = 1'b1;
      cycle();
      check("rst_dn_valid0", 16'(dn_valid0), 16'h0);
      check("rst_dn_invalid0", 16'(dn_invalid0), 16'h0);
      check("rst_dn_payload0", 16'(dn_payload0), 16'h05);
      check("rst_cnt0", 16'(cnt0), 16'h0);
      check("rst_up_ready0", 16'(up_ready0), 16'h1);
      check("rst_dn_valid1", 16'(dn_valid1), 16'h0);
      rst = 1'b0;

      // Randomised traffic against the queue models
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom % 64) == 0;
         flush      = ($urandom % 16) == 0;
         up_valid   = ($urandom % 4) != 0;
         up_invalid = ($urandom % 4) == 0;
         up_payload = 8'($urandom);
         dn_ready   = ($urandom % 3) != 0;
         cycle();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
